vend_multi_ctrl: RTL and testbench

- Parametrised successor to the team's single-soda/water vending controller.
- Supports N_PROD products with per-product prices, a bounded credit accumulator, and coin/selection/refund inputs with explicit priority.
- Product release and change return each use a valid/ready handshake; change is paid out as a greedy serial coin stream.
- Sits between the coin-acceptor front end and the product/coin ejector actuators.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/change_dispenser.sv | 43 ++++
 rtl/vend_multi_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_vend_multi_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the multi-product vending controller.
// Holds the controller state encoding, the legal coin values and the greedy
// change-coin selection used by both the controller and the change dispenser.
package vend_pkg;

  typedef enum logic [1:0] {
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;
  localparam logic [4:0] COIN_20 = 5'd20;

  function automatic logic is_legal_coin(input logic [4:0] c);
    return (c == COIN_5) || (c == COIN_10) || (c == COIN_20);
  endfunction

  // Largest coin not exceeding the amount; amounts are always multiples of 5.
  function automatic logic [4:0] greedy_coin(input logic [15:0] amount);
    if (amount >= 16'(COIN_20))
      return COIN_20;
    else if (amount >= 16'(COIN_10))
      return COIN_10;
    else
      return COIN_5;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: loads an amount and pays it out as a greedy coin stream
// (20/10/5) over a change_valid/change_ready handshake. done pulses on the
// handshake that pays the last coin.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_amt,
  input  logic         change_ready,
  output logic         change_valid,
  output logic [4:0]   change_coin,
  output logic         done
);

  logic [W-1:0] amt;
  logic [W-1:0] amt_rem;

  assign amt_rem = amt - W'(change_coin);
  assign done    = change_valid && change_ready && (amt_rem == '0);

  // Remaining amount and the coin on offer; the coin is held until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      amt          <= '0;
      change_valid <= 1'b0;
      change_coin  <= '0;
    end else if (load) begin
      amt          <= load_amt;
      change_valid <= (load_amt != '0);
      change_coin  <= greedy_coin(16'(load_amt));
    end else if (change_valid && change_ready) begin
      amt          <= amt_rem;
      change_valid <= (amt_rem != '0);
      if (amt_rem != '0)
        change_coin <= greedy_coin(16'(amt_rem));
    end
  end

endmodule

// File: rtl/vend_multi_ctrl.sv
// vend_multi_ctrl: N_PROD-product vending controller with bounded credit,
// prioritised refund/selection/coin inputs, a vend handshake and greedy change.
// Optional per-product stock counting is enabled by defining VEND_STOCK_COUNT_EN.
module vend_multi_ctrl
  import vend_pkg::*;
#(
  parameter int N_PROD = 4,
  parameter int CREDIT_W = 7,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {7'd90, 7'd35, 7'd70, 7'd55},
  parameter int MAX_CREDIT = 100,
`ifdef VEND_STOCK_COUNT_EN
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 10,
`endif
  localparam int SEL_W = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [4:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                refund,
  output logic                coin_accept,
  output logic                incorrect_coin,
  output logic                beeping,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_id,
  input  logic                vend_ready,
  output logic                change_valid,
  output logic [4:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] total,
  output logic                busy
`ifdef VEND_STOCK_COUNT_EN
  ,
  input  logic                restock,
  output logic [N_PROD-1:0]   sold_out
`endif
);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic [SEL_W-1:0]    vend_id_n;
  logic                vend_valid_n, coin_accept_n, incorrect_n, beep_n;
  logic                disp_load, disp_done, vend_hs;
  logic [CREDIT_W-1:0] disp_amt;
  logic [CREDIT_W-1:0] sel_price, vend_price, vend_change;
  logic [CREDIT_W:0]   coin_sum;
  logic                sel_in_range, sel_sold_out, sel_refused;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    price_of = '0;
    for (int i = 0; i < N_PROD; i++)
      if (idx == SEL_W'(i))
        price_of = PRICES[i*CREDIT_W +: CREDIT_W];
  endfunction

  assign sel_price    = price_of(sel);
  assign vend_price   = price_of(vend_id);
  assign vend_change  = credit - vend_price;
  assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(N_PROD));
  assign coin_sum     = {1'b0, credit} + (CREDIT_W+1)'(coin);
  assign sel_refused  = !sel_in_range || (sel_price > credit) || sel_sold_out;
  assign vend_hs      = (state == VEND) && vend_valid && vend_ready;
  assign total        = credit;
  assign busy         = (state != CREDIT);

`ifdef VEND_STOCK_COUNT_EN
  logic [STOCK_W-1:0] stock [N_PROD];

  // Per-product stock: reload on reset/restock, otherwise count down on vend.
  always_ff @(posedge clk) begin
    if (reset || restock) begin
      for (int i = 0; i < N_PROD; i++)
        stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (vend_hs) begin
      for (int i = 0; i < N_PROD; i++)
        if (vend_id == SEL_W'(i) && stock[i] != '0)
          stock[i] <= stock[i] - STOCK_W'(1);
    end
  end

  // Sold-out flags and the sold-out status of the current selection.
  always_comb begin
    sold_out     = '0;
    sel_sold_out = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      sold_out[i] = (stock[i] == '0);
      if (sel == SEL_W'(i) && stock[i] == '0)
        sel_sold_out = 1'b1;
    end
  end
`else
  assign sel_sold_out = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CREDIT;
      credit         <= '0;
      vend_id        <= '0;
      vend_valid     <= 1'b0;
      coin_accept    <= 1'b0;
      incorrect_coin <= 1'b0;
      beeping        <= 1'b0;
    end else begin
      state          <= state_n;
      credit         <= credit_n;
      vend_id        <= vend_id_n;
      vend_valid     <= vend_valid_n;
      coin_accept    <= coin_accept_n;
      incorrect_coin <= incorrect_n;
      beeping        <= beep_n;
    end
  end

  // Next state and next outputs; refund beats selection beats coin in CREDIT.
  always_comb begin
    state_n       = state;
    credit_n      = credit;
    vend_id_n     = vend_id;
    vend_valid_n  = vend_valid;
    coin_accept_n = 1'b0;
    incorrect_n   = 1'b0;
    beep_n        = 1'b0;
    disp_load     = 1'b0;
    disp_amt      = '0;
    case (state)
      CREDIT: begin
        if (refund && credit != '0) begin
          disp_load   = 1'b1;
          disp_amt    = credit;
          credit_n    = '0;
          state_n     = CHANGE;
          incorrect_n = coin_valid;
        end else if (sel_valid) begin
          incorrect_n = coin_valid;
          if (sel_refused) begin
            beep_n = 1'b1;
          end else begin
            vend_id_n    = sel;
            vend_valid_n = 1'b1;
            state_n      = VEND;
          end
        end else if (coin_valid) begin
          if (is_legal_coin(coin) && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_n      = coin_sum[CREDIT_W-1:0];
            coin_accept_n = 1'b1;
          end else begin
            incorrect_n = 1'b1;
          end
        end
      end
      VEND: begin
        incorrect_n = coin_valid;
        if (vend_hs) begin
          vend_valid_n = 1'b0;
          credit_n     = '0;
          if (vend_change != '0) begin
            disp_load = 1'b1;
            disp_amt  = vend_change;
            state_n   = CHANGE;
          end else begin
            state_n = CREDIT;
          end
        end
      end
      CHANGE: begin
        incorrect_n = coin_valid;
        if (disp_done)
          state_n = CREDIT;
      end
      default: state_n = CREDIT;
    endcase
  end

  change_dispenser #(
    .W(CREDIT_W)
  ) u_change (
    .clk          (clk),
    .reset        (reset),
    .load         (disp_load),
    .load_amt     (disp_amt),
    .change_ready (change_ready),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .done         (disp_done)
  );

endmodule

// File: tb/tb_vend_multi_ctrl.sv
// tb_vend_multi_ctrl: scoreboard bench for vend_multi_ctrl (default parameters).
// With VEND_STOCK_COUNT_EN defined the DUT is built with STOCK_INIT=1 and the
// stock scenario is added.
module tb_vend_multi_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [4:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       refund;
  logic       coin_accept;
  logic       incorrect_coin;
  logic       beeping;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       vend_ready;
  logic       change_valid;
  logic [4:0] change_coin;
  logic       change_ready;
  logic [6:0] total;
  logic       busy;
`ifdef VEND_STOCK_COUNT_EN
  logic       restock;
  logic [3:0] sold_out;
`endif

  int checks = 0;
  int failures = 0;
  int exp_total_q[$];
  int exp_vend_q[$];
  int exp_coin_q[$];
  int model_credit;

  always #5 clk = ~clk;

`ifdef VEND_STOCK_COUNT_EN
  vend_multi_ctrl #(.STOCK_INIT(1)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel(sel), .refund(refund),
    .coin_accept(coin_accept), .incorrect_coin(incorrect_coin), .beeping(beeping),
    .vend_valid(vend_valid), .vend_id(vend_id), .vend_ready(vend_ready),
    .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
    .total(total), .busy(busy), .restock(restock), .sold_out(sold_out)
  );
`else
  vend_multi_ctrl dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel(sel), .refund(refund),
    .coin_accept(coin_accept), .incorrect_coin(incorrect_coin), .beeping(beeping),
    .vend_valid(vend_valid), .vend_id(vend_id), .vend_ready(vend_ready),
    .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
    .total(total), .busy(busy)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input int val);
    coin_valid = 1'b1;
    coin = 5'(val);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic load_credit(input int amt);
    int left;
    left = amt;
    while (left >= 20) begin put_coin(20); left -= 20; end
    while (left >= 10) begin put_coin(10); left -= 10; end
    while (left >= 5)  begin put_coin(5);  left -= 5;  end
  endtask

  task automatic select(input int idx);
    sel_valid = 1'b1;
    sel = 2'(idx);
    tick();
    sel_valid = 1'b0;
  endtask

  // Pops expected change coins as the DUT offers them, stalling ready first.
  task automatic drain_change(input int stall, input string tag);
    int budget;
    int exp;
    budget = 200;
    while (exp_coin_q.size() > 0 && budget > 0) begin
      if (change_valid === 1'b1) begin
        exp = exp_coin_q[0];
        for (int s = 0; s < stall; s++) begin
          change_ready = 1'b0;
          tick();
          checks++;
          if (change_valid !== 1'b1 || change_coin !== 5'(exp)) begin
            failures++;
            $display("[TB] FAIL %s_hold: valid=%0b coin=%0d required valid=1 coin=%0d",
                     tag, change_valid, change_coin, exp);
          end
        end
        checks++;
        if (change_coin !== 5'(exp)) begin
          failures++;
          $display("[TB] FAIL %s_coin: got %0d required %0d", tag, change_coin, exp);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        void'(exp_coin_q.pop_front());
      end else begin
        tick();
      end
      budget--;
    end
    if (exp_coin_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: %0d coins still expected, required 0",
               tag, exp_coin_q.size());
      exp_coin_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (total !== 7'd0 || busy !== 1'b0 || vend_valid !== 1'b0 || change_valid !== 1'b0 ||
        coin_accept !== 1'b0 || incorrect_coin !== 1'b0 || beeping !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset: total=%0d busy=%0b vv=%0b cv=%0b ca=%0b ic=%0b bp=%0b required all 0",
               total, busy, vend_valid, change_valid, coin_accept, incorrect_coin, beeping);
    end
  endtask

  task automatic test_coins_exact_vend();
    int vals[4] = '{20, 20, 10, 5};
    int exp;
    model_credit = 0;
    foreach (vals[k]) begin
      model_credit += vals[k];
      exp_total_q.push_back(model_credit);
      put_coin(vals[k]);
      exp = exp_total_q.pop_front();
      checks++;
      if (coin_accept !== 1'b1 || total !== 7'(exp)) begin
        failures++;
        $display("[TB] FAIL coin_total: accept=%0b total=%0d required accept=1 total=%0d",
                 coin_accept, total, exp);
      end
    end
    tick();
    checks++;
    if (coin_accept !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coin_pulse: accept=%0b required 0", coin_accept);
    end
    vend_ready = 1'b1;
    exp_vend_q.push_back(0);
    select(0);
    exp = exp_vend_q.pop_front();
    checks++;
    if (vend_valid !== 1'b1 || vend_id !== 2'(exp) || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL exact_vend: vv=%0b id=%0d busy=%0b required vv=1 id=%0d busy=1",
               vend_valid, vend_id, busy, exp);
    end
    tick();
    vend_ready = 1'b0;
    checks++;
    if (vend_valid !== 1'b0 || total !== 7'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL exact_done: vv=%0b total=%0d cv=%0b busy=%0b required 0 0 0 0",
               vend_valid, total, change_valid, busy);
    end
  endtask

  task automatic test_change_stall();
    int exp;
    load_credit(90);
    checks++;
    if (total !== 7'd90) begin
      failures++;
      $display("[TB] FAIL stall_credit: total=%0d required 90", total);
    end
    exp_vend_q.push_back(0);
    select(0);
    coin_valid = 1'b1;
    coin = 5'd5;
    tick();
    coin_valid = 1'b0;
    exp = exp_vend_q[0];
    checks++;
    if (vend_valid !== 1'b1 || vend_id !== 2'(exp) || incorrect_coin !== 1'b1 || total !== 7'd90) begin
      failures++;
      $display("[TB] FAIL vend_hold_bounce: vv=%0b id=%0d ic=%0b total=%0d required 1 %0d 1 90",
               vend_valid, vend_id, incorrect_coin, total, exp);
    end
    tick();
    checks++;
    if (vend_valid !== 1'b1 || vend_id !== 2'(exp)) begin
      failures++;
      $display("[TB] FAIL vend_hold: vv=%0b id=%0d required 1 %0d", vend_valid, vend_id, exp);
    end
    void'(exp_vend_q.pop_front());
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    checks++;
    if (vend_valid !== 1'b0 || change_valid !== 1'b1 || total !== 7'd0) begin
      failures++;
      $display("[TB] FAIL vend_to_change: vv=%0b cv=%0b total=%0d required 0 1 0",
               vend_valid, change_valid, total);
    end
    exp_coin_q.push_back(20);
    exp_coin_q.push_back(10);
    exp_coin_q.push_back(5);
    drain_change(3, "change35");
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL change35_end: cv=%0b busy=%0b required 0 0", change_valid, busy);
    end
  endtask

  task automatic test_illegal_coin();
    load_credit(90);
    put_coin(7);
    checks++;
    if (incorrect_coin !== 1'b1 || coin_accept !== 1'b0 || total !== 7'd90) begin
      failures++;
      $display("[TB] FAIL coin7: ic=%0b ca=%0b total=%0d required 1 0 90",
               incorrect_coin, coin_accept, total);
    end
    put_coin(20);
    checks++;
    if (incorrect_coin !== 1'b1 || coin_accept !== 1'b0 || total !== 7'd90) begin
      failures++;
      $display("[TB] FAIL overflow: ic=%0b ca=%0b total=%0d required 1 0 90",
               incorrect_coin, coin_accept, total);
    end
    put_coin(10);
    checks++;
    if (coin_accept !== 1'b1 || total !== 7'd100) begin
      failures++;
      $display("[TB] FAIL max_credit: ca=%0b total=%0d required 1 100", coin_accept, total);
    end
    for (int k = 0; k < 5; k++) exp_coin_q.push_back(20);
    refund = 1'b1;
    tick();
    refund = 1'b0;
    checks++;
    if (total !== 7'd0 || change_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL refund100: total=%0d cv=%0b required 0 1", total, change_valid);
    end
    drain_change(0, "refund100");
  endtask

  task automatic test_beep();
    load_credit(30);
    select(1);
    checks++;
    if (beeping !== 1'b1 || total !== 7'd30 || vend_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL beep_price: bp=%0b total=%0d vv=%0b busy=%0b required 1 30 0 0",
               beeping, total, vend_valid, busy);
    end
    select(3);
    checks++;
    if (beeping !== 1'b1 || total !== 7'd30 || vend_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL beep_sel3: bp=%0b total=%0d vv=%0b required 1 30 0",
               beeping, total, vend_valid);
    end
    exp_coin_q.push_back(20);
    exp_coin_q.push_back(10);
    refund = 1'b1;
    tick();
    refund = 1'b0;
    checks++;
    if (total !== 7'd0 || beeping !== 1'b0) begin
      failures++;
      $display("[TB] FAIL refund30: total=%0d bp=%0b required 0 0", total, beeping);
    end
    drain_change(0, "refund30");
  endtask

  task automatic test_priority_reset();
    load_credit(40);
    refund = 1'b1;
    sel_valid = 1'b1;
    sel = 2'd2;
    coin_valid = 1'b1;
    coin = 5'd5;
    tick();
    refund = 1'b0;
    sel_valid = 1'b0;
    coin_valid = 1'b0;
    exp_coin_q.push_back(20);
    exp_coin_q.push_back(20);
    checks++;
    if (incorrect_coin !== 1'b1 || vend_valid !== 1'b0 || beeping !== 1'b0 || total !== 7'd0 ||
        change_valid !== 1'b1 || change_coin !== 5'(exp_coin_q[0])) begin
      failures++;
      $display("[TB] FAIL priority: ic=%0b vv=%0b bp=%0b total=%0d cv=%0b coin=%0d required 1 0 0 0 1 %0d",
               incorrect_coin, vend_valid, beeping, total, change_valid, change_coin, exp_coin_q[0]);
    end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    void'(exp_coin_q.pop_front());
    checks++;
    if (change_valid !== 1'b1 || change_coin !== 5'(exp_coin_q[0]) || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL priority_second: cv=%0b coin=%0d busy=%0b required 1 %0d 1",
               change_valid, change_coin, busy, exp_coin_q[0]);
    end
    exp_coin_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (change_valid !== 1'b0 || total !== 7'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_change_reset: cv=%0b total=%0d busy=%0b required 0 0 0",
               change_valid, total, busy);
    end
    refund = 1'b1;
    tick();
    refund = 1'b0;
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || beeping !== 1'b0) begin
      failures++;
      $display("[TB] FAIL refund_zero: cv=%0b busy=%0b bp=%0b required 0 0 0",
               change_valid, busy, beeping);
    end
  endtask

`ifdef VEND_STOCK_COUNT_EN
  task automatic test_stock();
    checks++;
    if (sold_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL stock_init: sold_out=%b required 0000", sold_out);
    end
    load_credit(40);
    vend_ready = 1'b1;
    select(2);
    tick();
    vend_ready = 1'b0;
    exp_coin_q.push_back(5);
    drain_change(0, "stock_change");
    checks++;
    if (sold_out !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL stock_sold: sold_out=%b required 0100", sold_out);
    end
    load_credit(40);
    select(2);
    checks++;
    if (beeping !== 1'b1 || vend_valid !== 1'b0 || total !== 7'd40) begin
      failures++;
      $display("[TB] FAIL stock_beep: bp=%0b vv=%0b total=%0d required 1 0 40",
               beeping, vend_valid, total);
    end
    restock = 1'b1;
    tick();
    restock = 1'b0;
    checks++;
    if (sold_out !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL restock: sold_out=%b required 0000", sold_out);
    end
    exp_coin_q.push_back(20);
    exp_coin_q.push_back(20);
    refund = 1'b1;
    tick();
    refund = 1'b0;
    drain_change(0, "stock_refund");
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    coin_valid = 1'b0;
    coin = '0;
    sel_valid = 1'b0;
    sel = '0;
    refund = 1'b0;
    vend_ready = 1'b0;
    change_ready = 1'b0;
`ifdef VEND_STOCK_COUNT_EN
    restock = 1'b0;
`endif
    test_reset();
    test_coins_exact_vend();
    test_change_stall();
    test_illegal_coin();
    test_beep();
    test_priority_reset();
`ifdef VEND_STOCK_COUNT_EN
    test_stock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
